wom_reader: RTL and testbench

- Read-side engine for the write-output memory (WOM) filled by the vector CPU Memory stage.
- On a start command, it reads a block of 32-bit WOM words through a synchronous read port. Each word is unpacked into four 8-bit pixels, emitted byte 0 (bits 7:0) first.
- Pixels leave on a valid/ready byte stream toward the host/display link. The block sits between WOM read port and output link, beside vector_cpu.

---
 rtl/wom_reader.sv | 127 ++++++++++++
 tb/tb_wom_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wom_reader.sv
// WOM read-side engine: reads a block of 32-bit words and streams them as bytes, LSB first.
// Optional macro WOM_READER_PREFETCH_EN adds a one-word prefetch buffer for 4 cycles/word.
module wom_reader #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, RD, LAT, SEND, FIN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  rem;
  logic [31:0]       shift;
  logic [1:0]        idx;
  logic              hs, last_hs, pf_issue, pf_hit;

`ifdef WOM_READER_PREFETCH_EN
  logic        pf_valid, pf_pend, first;
  logic [31:0] pf_buf;
  // Only the first SEND cycle of a word may fetch ahead, so at most one read is in flight.
  assign pf_issue = (state == SEND) && first && (rem != '0) && !pf_valid && !pf_pend;
  assign pf_hit   = pf_valid;
`else
  assign pf_issue = 1'b0;
  assign pf_hit   = 1'b0;
`endif

  assign hs       = (state == SEND) && out_ready;
  assign last_hs  = hs && (idx == 2'd3);
  assign mem_addr = addr;
  assign out_data = shift[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_rd_en = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (word_count == '0) ? FIN : RD;
      end
      RD: begin
        mem_rd_en = 1'b1;
        state_nx  = LAT;
      end
      LAT: state_nx = SEND;
      SEND: begin
        out_valid = 1'b1;
        mem_rd_en = pf_issue;
        if (last_hs && !pf_hit) state_nx = (rem != '0) ? RD : FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr  <= '0;
      rem   <= '0;
      shift <= '0;
      idx   <= '0;
`ifdef WOM_READER_PREFETCH_EN
      pf_valid <= 1'b0;
      pf_pend  <= 1'b0;
      first    <= 1'b0;
      pf_buf   <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        addr <= base_addr;
        rem  <= word_count;
      end
      if (state == LAT) begin
        shift <= mem_rdata;
        idx   <= '0;
        addr  <= addr + 1'b1;
        rem   <= rem - 1'b1;
      end
      if (hs) begin
        shift <= {8'h00, shift[31:8]};
        idx   <= idx + 2'd1;
      end
`ifdef WOM_READER_PREFETCH_EN
      first <= (state == LAT) || (last_hs && pf_valid);
      if (pf_issue) pf_pend <= 1'b1;
      if (pf_pend) begin
        pf_buf   <= mem_rdata;
        pf_valid <= 1'b1;
        pf_pend  <= 1'b0;
        addr     <= addr + 1'b1;
        rem      <= rem - 1'b1;
      end
      // Reload overrides the shift above; idx has already wrapped to 0 on the 4th byte.
      if (last_hs && pf_valid) begin
        shift    <= pf_buf;
        pf_valid <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_wom_reader.sv
// Directed bench for wom_reader: stream order, latency, back-pressure, wrap, ignored start, reset abort.
module tb_wom_reader;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [15:0] base_addr = '0, word_count = '0;
  logic        mem_rd_en, out_valid, busy, done;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  out_data;

  always #5 clk = ~clk;

  wom_reader #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  logic [31:0] wom [0:65535];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= wom[mem_addr];

  int total = 0, bad = 0, cyc = 0;
  int done_cnt = 0, done_cyc = -1, s_cyc = 0, viol = 0;
  bq_t        got_q;
  int         hs_cyc_q[$];
  logic [15:0] rd_q[$];
  logic pv = 1'b0, ph = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin got_q.push_back(out_data); hs_cyc_q.push_back(cyc); end
      if (mem_rd_en) rd_q.push_back(mem_addr);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (pv && !ph && !out_valid) viol++;
    end
    pv = out_valid;
    ph = out_valid && out_ready;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    got_q.delete(); hs_cyc_q.delete(); rd_q.delete();
    done_cnt = 0; done_cyc = -1; viol = 0;
  endtask

  task automatic launch(input logic [15:0] b, input logic [15:0] n);
    clear();
    base_addr = b; word_count = n; start = 1'b1;
    tick();
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done_cnt == 0; i++) tick();
    chk("done_seen", 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic check_stream(input string tag, input bq_t e);
    chk({tag, "_len"}, 32'(got_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      if (i < got_q.size()) chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(e[i]));
  endtask

  task automatic check_rd(input string tag, input logic [15:0] a0, input logic [15:0] a1);
    chk({tag, "_nrd"}, 32'(rd_q.size()), 32'd2);
    if (rd_q.size() >= 2) begin
      chk({tag, "_rd0"}, 32'(rd_q[0]), 32'(a0));
      chk({tag, "_rd1"}, 32'(rd_q[1]), 32'(a1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    bq_t e;
    wom[16'h0010] = 32'h44332211;
    wom[16'h0011] = 32'h88776655;
    wom[16'hFFFF] = 32'hDDCCBBAA;
    wom[16'h0000] = 32'h04030201;
    for (int i = 0; i < 4; i++) wom[16'h0040 + 16'(i)] = 32'h0d0c0b0a + 32'(i) * 32'h10101010;

    // reset values
    #12;
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_addr",  32'(mem_addr),  32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    tick();
    rst = 1'b1;
    tick(2);

    // basic two-word block
    launch(16'h0010, 16'd2);
    wait_done();
    e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    check_stream("basic", e);
    check_rd("basic", 16'h0010, 16'h0011);
    if (hs_cyc_q.size() == 8) begin
      chk("basic_first_lat", 32'(hs_cyc_q[0] - s_cyc), 32'd2);
      chk("basic_done_after_last", 32'(done_cyc - hs_cyc_q[7]), 32'd1);
    end
`ifndef WOM_READER_PREFETCH_EN
    chk("basic_cycles", 32'(done_cyc - s_cyc), 32'd12);
`endif
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);
    chk("basic_viol", 32'(viol), 32'd0);
    tick();
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_idle_done", 32'(done), 32'd0);

    // zero-length block
    clear();
    base_addr = 16'h0030; word_count = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd1);
    chk("zero_valid", 32'(out_valid), 32'd0);
    tick();
    chk("zero_done_off", 32'(done), 32'd0);
    chk("zero_busy_off", 32'(busy), 32'd0);
    tick(3);
    chk("zero_nrd", 32'(rd_q.size()), 32'd0);
    chk("zero_nbytes", 32'(got_q.size()), 32'd0);
    chk("zero_done_cnt", 32'(done_cnt), 32'd1);

    // back-pressure on byte 0x33
    launch(16'h0010, 16'd2);
    for (int i = 0; i < 20 && !(out_valid && out_data == 8'h33); i++) tick();
    out_ready = 1'b0;
    chk("bp_data0", 32'(out_data), 32'h33);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h33);
    end
`ifdef WOM_READER_PREFETCH_EN
    chk("bp_nrd", 32'(rd_q.size()), 32'd2);
`else
    chk("bp_nrd", 32'(rd_q.size()), 32'd1);
`endif
    out_ready = 1'b1;
    wait_done();
    check_stream("bp", e);
    chk("bp_viol", 32'(viol), 32'd0);
    tick(2);

    // address wrap
    launch(16'hFFFF, 16'd2);
    wait_done();
    check_rd("wrap", 16'hFFFF, 16'h0000);
    e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
    check_stream("wrap", e);
    tick(2);

    // start while busy is ignored
    launch(16'h0010, 16'd2);
    tick(3);
    base_addr = 16'h0020; word_count = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    check_stream("midstart", e);
    tick(10);
    check_rd("midstart", 16'h0010, 16'h0011);
    chk("midstart_done_cnt", 32'(done_cnt), 32'd1);
    chk("midstart_busy", 32'(busy), 32'd0);

    // reset during word 2 of 4
    launch(16'h0040, 16'd4);
    for (int i = 0; i < 60 && got_q.size() < 5; i++) tick();
    chk("abort_pre_valid", 32'(out_valid), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_data",  32'(out_data),  32'd0);
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_addr",  32'(mem_addr),  32'd0);
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_nbytes", 32'(got_q.size()), 32'd5);
    launch(16'h0011, 16'd1);
    wait_done();
    e = '{8'h55, 8'h66, 8'h77, 8'h88};
    check_stream("restart", e);
    chk("restart_nrd", 32'(rd_q.size()), 32'd1);
    if (rd_q.size() >= 1) chk("restart_rd0", 32'(rd_q[0]), 32'h0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
